// File: rtl/mmcm_drp_reconfig.sv
// Replays a bank of DRP read-modify-write entries into an MMCM while holding it in reset,
// then releases the reset and waits for lock. Every wait is bounded by a shared timeout counter.
module mmcm_drp_reconfig #(
    parameter int NUM_ENTRIES = 23,
    parameter int TIMEOUT     = 1024
) (
    input  logic        dclk_i,
    input  logic        rst_i,
    input  logic        sen_i,
    input  logic        saddr_i,
    output logic [5:0]  tbl_addr_o,
    input  logic [38:0] tbl_data_i,
    output logic [6:0]  daddr_o,
    output logic [15:0] di_o,
    output logic        den_o,
    output logic        dwe_o,
    input  logic [15:0] do_i,
    input  logic        drdy_i,
    output logic        mmcm_rst_o,
    input  logic        locked_i,
    output logic        srdy_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [3:0] {
        IDLE, RESTART, WAIT_UNLOCK, READ, WAIT_RD,
        WRITE, WAIT_WR, RELEASE, WAIT_LOCK, DONE
    } state_e;

    localparam logic [4:0]  LAST_IDX = 5'(NUM_ENTRIES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        bank_q, bank_d;
    logic [4:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timed_out;
    logic        in_wait;

    // NOTE: sequential state is updated with <= only; the combinational blocks below use =.
    always_ff @(posedge dclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d   = state_q;
        bank_d    = bank_q;
        idx_d     = idx_q;
        err_d     = err_q;
        daddr_d   = daddr_q;
        di_d      = di_q;
        mask_d    = mask_q;
        data_d    = data_q;
        timed_out = (cnt_q == TO_LAST);
        in_wait   = 1'b0;
        unique case (state_q)
            IDLE: if (sen_i) begin
                bank_d  = saddr_i;
                idx_d   = '0;
                err_d   = 1'b0;
                state_d = RESTART;
            end
            RESTART: state_d = WAIT_UNLOCK;
            WAIT_UNLOCK: begin
                in_wait = 1'b1;
                if (!locked_i)      state_d = READ;
                else if (timed_out) begin err_d = 1'b1; state_d = RELEASE; end
            end
            READ: begin
                daddr_d = tbl_data_i[38:32];
                mask_d  = tbl_data_i[31:16];
                data_d  = tbl_data_i[15:0];
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                in_wait = 1'b1;
                // A set mask bit keeps the MMCM's current bit; a clear one takes the table bit.
                if (drdy_i) begin
                    di_d    = (do_i & mask_q) | (data_q & ~mask_q);
                    state_d = WRITE;
                end else if (timed_out) begin
                    err_d = 1'b1; state_d = RELEASE;
                end
            end
            WRITE: state_d = WAIT_WR;
            WAIT_WR: begin
                in_wait = 1'b1;
                if (drdy_i) begin
                    if (idx_q == LAST_IDX) state_d = RELEASE;
                    else begin idx_d = idx_q + 5'd1; state_d = READ; end
                end else if (timed_out) begin
                    err_d = 1'b1; state_d = RELEASE;
                end
            end
            RELEASE: state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                in_wait = 1'b1;
                if (locked_i)       state_d = DONE;
                else if (timed_out) begin err_d = 1'b1; state_d = DONE; end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The counter restarts on every state entry and only runs while waiting.
        cnt_d = (state_d != state_q || !in_wait) ? '0 : cnt_q + 16'd1;
    end

    always_comb begin
        den_o      = (state_q == READ) || (state_q == WRITE);
        dwe_o      = (state_q == WRITE);
        mmcm_rst_o = state_q inside {RESTART, WAIT_UNLOCK, READ, WAIT_RD, WRITE, WAIT_WR};
        srdy_o     = (state_q == DONE);
        busy_o     = (state_q != IDLE);
        err_o      = err_q;
        tbl_addr_o = {bank_q, idx_q};
        di_o       = di_q;
        // The read address comes straight from the table; the write reuses the latched copy.
        daddr_o    = (state_q == READ) ? tbl_data_i[38:32] : daddr_q;
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Scoreboard bench for mmcm_drp_reconfig: a DRP/lock model answers the DUT and every
// DRP request is popped against the expected read/write queues.
module tb_mmcm_drp_reconfig;

    localparam int NE = 2;
    localparam int TO = 16;

    typedef struct { logic [5:0] ta; logic [6:0] da; } rd_t;
    typedef struct { logic [6:0] da; logic [15:0] d; } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, sen = 1'b0, saddr = 1'b0;
    logic [5:0]  tbl_addr;
    logic [38:0] tbl_data;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den, dwe;
    logic [15:0] do_r = '0;
    logic        drdy_r = 1'b0, drdy_force = 1'b0;
    logic        drdy;
    logic        mmcm_rst, locked = 1'b1, srdy, busy, err;

    logic [38:0] tbl [64];
    logic [15:0] drp_mem [128];
    rd_t exp_rd [$];
    wr_t exp_wr [$];
    rd_t re;
    wr_t we;

    int checks = 0, errors = 0;
    int den_count = 0;
    int pend_cnt = 0, drp_lat = 3;
    bit drp_mute = 0, lock_stuck = 0, prev_den = 0, pend_wr = 0;
    logic [6:0]  pend_addr = '0;
    logic [15:0] pend_di = '0;
    int ul_cnt = 0, rise_cnt = 0;

    always #5 clk = ~clk;

    assign drdy     = drdy_r | drdy_force;
    assign tbl_data = tbl[tbl_addr];

    mmcm_drp_reconfig #(.NUM_ENTRIES(NE), .TIMEOUT(TO)) dut (
        .dclk_i(clk), .rst_i(rst), .sen_i(sen), .saddr_i(saddr),
        .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
        .daddr_o(daddr), .di_o(di), .den_o(den), .dwe_o(dwe),
        .do_i(do_r), .drdy_i(drdy), .mmcm_rst_o(mmcm_rst), .locked_i(locked),
        .srdy_o(srdy), .busy_o(busy), .err_o(err)
    );

    // DRP responder and request monitor: DRDY follows DEN by drp_lat cycles.
    always @(negedge clk) begin
        drdy_r = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                drdy_r = 1'b1;
                if (pend_wr) drp_mem[pend_addr] = pend_di;
                else         do_r = drp_mem[pend_addr];
            end
        end
        if (den === 1'b1) begin
            den_count++;
            checks++;
            if (prev_den || pend_cnt > 0) begin
                errors++;
                $display("FAIL den_spacing: DEN with prev_den=%0b pending=%0d, required neither", prev_den, pend_cnt);
            end
            checks++;
            if (dwe === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h di=%h, required no write", daddr, di);
                end else begin
                    we = exp_wr.pop_front();
                    if (daddr !== we.da || di !== we.d) begin
                        errors++;
                        $display("FAIL write: addr=%h di=%h, required addr=%h di=%h", daddr, di, we.da, we.d);
                    end
                end
            end else begin
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: tbl_addr=%0d addr=%h, required no read", tbl_addr, daddr);
                end else begin
                    re = exp_rd.pop_front();
                    if (tbl_addr !== re.ta || daddr !== re.da) begin
                        errors++;
                        $display("FAIL read: tbl_addr=%0d addr=%h, required tbl_addr=%0d addr=%h",
                                 tbl_addr, daddr, re.ta, re.da);
                    end
                end
            end
            if (!drp_mute) begin
                pend_cnt  = drp_lat;
                pend_wr   = dwe;
                pend_addr = daddr;
                pend_di   = di;
            end
        end
        prev_den = (den === 1'b1);
    end

    // Lock model: LOCKED drops 3 cycles into MMCM reset, returns 5 cycles after release.
    always @(negedge clk) begin
        if (mmcm_rst === 1'b1) begin
            rise_cnt = 0;
            if (!lock_stuck) begin
                if (ul_cnt >= 2) locked = 1'b0;
                else ul_cnt++;
            end
        end else begin
            ul_cnt = 0;
            if (!locked) begin
                if (rise_cnt >= 4) locked = 1'b1;
                else rise_cnt++;
            end
        end
    end

    task automatic init_mem();
        drp_mem[7'h08] = 16'h1234;
        drp_mem[7'h10] = 16'hABCD;
        drp_mem[7'h21] = 16'h5A5A;
        drp_mem[7'h22] = 16'hF00F;
    endtask

    task automatic push_full_pass();
        exp_rd.push_back('{ta: 6'd32, da: 7'h08});
        exp_rd.push_back('{ta: 6'd33, da: 7'h10});
        exp_wr.push_back('{da: 7'h08, d: 16'h1ABC});
        exp_wr.push_back('{da: 7'h10, d: 16'h12CD});
    endtask

    task automatic start_seq(input logic bank);
        saddr = bank;
        sen   = 1'b1;
        @(negedge clk);
        sen = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL start: busy=%b err=%b, required busy=1 err=0", busy, err);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (srdy === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_srdy: no SRDY within 400 cycles, required one pulse", tag);
        end
        @(negedge clk);
        checks++;
        if (srdy !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: srdy=%b busy=%b after DONE, required 0 0", tag, srdy, busy);
        end
    endtask

    task automatic check_queues(input string tag);
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_queues: %0d reads %0d writes left, required 0 0", tag, exp_rd.size(), exp_wr.size());
        end
    endtask

    task automatic check_err(input string tag, input logic want);
        checks++;
        if (err !== want) begin
            errors++;
            $display("FAIL %s_err: err=%b, required %b", tag, err, want);
        end
    endtask

    task automatic check_dens(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s_den_count: %0d, required %0d", tag, got, want);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({mmcm_rst, den, dwe, srdy, busy, err, daddr, di, tbl_addr} !== '0) begin
            errors++;
            $display("FAIL %s: mrst=%b den=%b dwe=%b srdy=%b busy=%b err=%b daddr=%h di=%h ta=%0d, required all 0",
                     tag, mmcm_rst, den, dwe, srdy, busy, err, daddr, di, tbl_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sen = 1'b1; saddr = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        rst = 1'b0; sen = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_sen: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_full_pass();
        int d0;
        init_mem();
        push_full_pass();
        d0 = den_count;
        start_seq(1'b1);
        wait_done("full");
        check_err("full", 1'b0);
        check_dens("full", den_count - d0, 2 * NE);
        check_queues("full");
    endtask

    task automatic test_mask_extremes();
        init_mem();
        exp_rd.push_back('{ta: 6'd0, da: 7'h21});
        exp_rd.push_back('{ta: 6'd1, da: 7'h22});
        exp_wr.push_back('{da: 7'h21, d: 16'h5A5A});
        exp_wr.push_back('{da: 7'h22, d: 16'h00FF});
        start_seq(1'b0);
        wait_done("mask");
        check_err("mask", 1'b0);
        check_queues("mask");
    endtask

    task automatic test_timeout_read();
        int d0, n, nden, nrel;
        init_mem();
        drp_mute = 1;
        exp_rd.push_back('{ta: 6'd0, da: 7'h21});
        d0 = den_count; n = 0; nden = -1; nrel = -1;
        start_seq(1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (den === 1'b1 && nden < 0) nden = n;
            if (nden >= 0 && mmcm_rst === 1'b0) begin nrel = n; break; end
        end
        checks++;
        if (nden < 0 || nrel - nden != TO + 1) begin
            errors++;
            $display("FAIL rd_timeout_latency: release %0d cycles after read, required %0d", nrel - nden, TO + 1);
        end
        check_err("rd_timeout_release", 1'b1);
        wait_done("rd_timeout");
        check_err("rd_timeout_done", 1'b1);
        check_dens("rd_timeout", den_count - d0, 1);
        check_queues("rd_timeout");
        drp_mute = 0;
    endtask

    task automatic test_sen_while_busy();
        int d0;
        bit seen = 0;
        @(negedge clk);
        drdy_force = 1'b1;
        @(negedge clk);
        drdy_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || den !== 1'b0) begin
                errors++;
                $display("FAIL stray_drdy: busy=%b den=%b, required 0 0", busy, den);
            end
        end
        init_mem();
        push_full_pass();
        d0 = den_count;
        saddr = 1'b1; sen = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            sen   = (i % 3 == 0);
            saddr = (i % 2 == 1);
            @(negedge clk);
            if (srdy === 1'b1) begin seen = 1; break; end
        end
        sen = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy_sen_srdy: no SRDY within 400 cycles, required one pulse");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_sen_restart: busy=%b after DONE, required 0", busy);
            end
        end
        check_dens("busy_sen", den_count - d0, 2 * NE);
        check_queues("busy_sen");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        init_mem();
        push_full_pass();
        start_seq(1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (den === 1'b1 && dwe === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_write: no write within 200 cycles, required one");
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset_mid_values");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || den !== 1'b0 || mmcm_rst !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_idle: busy=%b den=%b mrst=%b, required 0 0 0", busy, den, mmcm_rst);
            end
        end
        checks++;
        if (exp_rd.size() != 1 || exp_wr.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_abandon: %0d reads %0d writes left, required 1 1", exp_rd.size(), exp_wr.size());
        end
        exp_rd.delete();
        exp_wr.delete();
        test_full_pass();
    endtask

    task automatic test_lock_stuck();
        int d0, hi;
        bit seen = 0;
        lock_stuck = 1;
        d0 = den_count;
        start_seq(1'b0);
        hi = (mmcm_rst === 1'b1) ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (srdy === 1'b1) begin seen = 1; break; end
            if (mmcm_rst === 1'b1) hi++;
        end
        checks++;
        if (!seen || hi != TO + 1) begin
            errors++;
            $display("FAIL lock_stuck_release: srdy_seen=%0b mmcm_rst high %0d cycles, required 1 and %0d",
                     seen, hi, TO + 1);
        end
        check_err("lock_stuck", 1'b1);
        @(negedge clk);
        check_dens("lock_stuck", den_count - d0, 0);
        lock_stuck = 0;
        test_full_pass();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbl[i] = '0;
        for (int i = 0; i < 128; i++) drp_mem[i] = '0;
        tbl[32] = {7'h08, 16'hF000, 16'h0ABC};
        tbl[33] = {7'h10, 16'h00FF, 16'h1200};
        tbl[0]  = {7'h21, 16'hFFFF, 16'h1111};
        tbl[1]  = {7'h22, 16'h0000, 16'h00FF};
        test_reset();
        test_full_pass();
        test_mask_extremes();
        test_timeout_read();
        test_sen_while_busy();
        test_reset_mid();
        test_lock_stuck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1);
    end

endmodule
